// File: rtl/crc_frame_rx_if.sv
// crc_frame_rx_if: UART byte input, CRC block link and AES-side frame handshake
//   master drives rx_byte/rx_valid, crc_in and frame_ready; slave drives crc_data/crc_en and frame_data/frame_valid
interface crc_frame_rx_if;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [111:0] crc_data;
    logic         crc_en;
    logic [15:0]  crc_in;
    logic [111:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;
    modport master (
        output rx_byte, rx_valid, crc_in, frame_ready,
        input  crc_data, crc_en, frame_data, frame_valid
    );
    modport slave (
        input  rx_byte, rx_valid, crc_in, frame_ready,
        output crc_data, crc_en, frame_data, frame_valid
    );
endinterface

// File: rtl/crc_frame_rx.sv
// crc_frame_rx: assembles 14 payload bytes + 2 CRC bytes, checks CRC, hands good frames to AES
//   clk, rst            rising-edge clock, synchronous active-high reset
//   bus (slave)         rx_byte/rx_valid in, crc_data/crc_en out, crc_in in, frame_data/frame_valid out, frame_ready in
//   crc_err             1-cycle pulse, CRC mismatch, frame dropped
//   timeout_err         1-cycle pulse, partial frame aborted after inter-byte timeout
//   overrun_err         1-cycle pulse, byte arrived while not accepting
//   busy                high in any state other than IDLE
module crc_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic           clk,
    input  logic           rst,
    crc_frame_rx_if.slave  bus,
    output logic           crc_err,
    output logic           timeout_err,
    output logic           overrun_err,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} state_t;
    state_t state, state_n;
    logic [3:0] cnt, wr_idx;
    logic [111:0] payload;
    logic [15:0] rxcrc;
    logic [TO_W-1:0] to_cnt;
    logic handshake, accept, to_exp, crc_ok;
    always_comb begin
        handshake = state == HOLD && bus.frame_ready;
        accept    = bus.rx_valid && (state == IDLE || state == COLLECT || handshake);
        // expiry is the idle cycle whose increment would reach TIMEOUT_CYCLES; a byte in that cycle still wins
        to_exp    = state == COLLECT && !bus.rx_valid && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
        crc_ok    = bus.crc_in == rxcrc;
        // a byte accepted outside COLLECT always starts a new frame
        wr_idx    = state == COLLECT ? cnt : 4'd0;
        state_n   = state;
        case (state)
            IDLE:    state_n = bus.rx_valid ? COLLECT : IDLE;
            COLLECT: state_n = (accept && cnt == 4'd15) ? CHECK : to_exp ? IDLE : COLLECT;
            CHECK:   state_n = crc_ok ? HOLD : IDLE;
            HOLD:    state_n = !bus.frame_ready ? HOLD : bus.rx_valid ? COLLECT : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            payload         <= '0;
            rxcrc           <= '0;
            to_cnt          <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            crc_err         <= 1'b0;
            timeout_err     <= 1'b0;
            overrun_err     <= 1'b0;
        end else begin
            state       <= state_n;
            crc_err     <= state == CHECK && !crc_ok;
            timeout_err <= to_exp;
            overrun_err <= bus.rx_valid && (state == CHECK || (state == HOLD && !bus.frame_ready));
            if (accept) begin
                cnt    <= wr_idx + 4'd1;
                to_cnt <= '0;
                if (wr_idx < 4'd14)
                    payload[{4'd13 - wr_idx, 3'b000} +: 8] <= bus.rx_byte;
                else if (wr_idx == 4'd14)
                    rxcrc[15:8] <= bus.rx_byte;
                else
                    rxcrc[7:0] <= bus.rx_byte;
            end else if (to_exp) begin
                cnt    <= '0;
                to_cnt <= '0;
            end else if (state == COLLECT) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == CHECK && crc_ok) begin
                bus.frame_data  <= payload;
                bus.frame_valid <= 1'b1;
            end else if (handshake) begin
                bus.frame_valid <= 1'b0;
            end
        end
    end
    assign bus.crc_data = payload;
    assign bus.crc_en   = state == CHECK;
    assign busy         = state != IDLE;
endmodule

// File: tb/tb_crc_frame_rx.sv
// tb_crc_frame_rx: directed and randomized frames against a polynomial-division CRC reference
module tb_crc_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic crc_err, timeout_err, overrun_err, busy;
    crc_frame_rx_if bus();
    crc_frame_rx #(.TIMEOUT_CYCLES(20), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .crc_err(crc_err), .timeout_err(timeout_err), .overrun_err(overrun_err), .busy(busy)
    );
    always #5 clk = ~clk;

    // remainder of payload(x)*x^16 divided by x^16+x^15+x^2+1, zero initial value
    function automatic logic [15:0] crc16(input logic [111:0] d);
        logic [127:0] r;
        r = {d, 16'h0};
        for (int i = 127; i >= 16; i--)
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h18005;
        return r[15:0];
    endfunction

    always_comb bus.crc_in = bus.crc_en ? crc16(bus.crc_data) : 16'h0;

    int checks = 0, errors = 0, cyc = 0, last = 0, rd = 0;
    int n_crc = 0, n_to = 0, n_ovr = 0, n_fv = 0, n_unst = 0, to_cyc = 0, fv_rise = 0;
    logic fv_q = 1'b0;
    logic [111:0] fd_q = '0;
    logic [111:0] got[$];
    logic [111:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid && bus.frame_ready) got.push_back(bus.frame_data);
        n_crc <= n_crc + int'(crc_err);
        n_to  <= n_to + int'(timeout_err);
        n_ovr <= n_ovr + int'(overrun_err);
        n_fv  <= n_fv + int'(bus.frame_valid);
        if (timeout_err) to_cyc <= cyc;
        if (bus.frame_valid && !fv_q) fv_rise <= cyc;
        if (bus.frame_valid && fv_q && bus.frame_data != fd_q) n_unst <= n_unst + 1;
        fv_q <= bus.frame_valid;
        fd_q <= bus.frame_data;
    end

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        last = cyc;
    endtask

    function automatic logic [7:0] byte_of(input logic [111:0] p, input logic [15:0] c, input int k);
        return k < 14 ? p[111 - 8*k -: 8] : k == 14 ? c[15:8] : c[7:0];
    endfunction

    task automatic send_frame(input logic [111:0] p, input logic [15:0] c, input int gap);
        for (int k = 0; k < 16; k++) begin
            send(byte_of(p, c, k));
            if (k < 15) tick(gap);
        end
    endtask

    function automatic logic [111:0] rnd();
        logic [111:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) p = {p[79:0], 32'($urandom())};
        return p;
    endfunction

    task automatic expect_frame(input string tag, input logic [111:0] e);
        if (got.size() > rd) begin
            chk(tag, got[rd], e);
            rd++;
        end else begin
            chki({tag, "_missing"}, got.size(), rd + 1);
        end
    endtask

    task automatic wait_fv(input int max);
        int n = 0;
        while (!bus.frame_valid && n < max) begin
            tick(1);
            n++;
        end
        chk("fv_wait", bus.frame_valid, 1);
    endtask

    initial begin
        logic [111:0] p, q;
        logic [15:0] c;
        int b, e0, f0, u0, l5, ncor;
        bus.rx_byte = '0;
        bus.rx_valid = 1'b0;
        bus.frame_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_fv", bus.frame_valid, 0);
        chk("rst_fd", bus.frame_data, 0);
        chk("rst_crc_data", bus.crc_data, 0);
        chk("rst_crc_en", bus.crc_en, 0);
        chk("rst_pulses", {crc_err, timeout_err, overrun_err}, 0);
        rst = 1'b0;
        tick(1);

        e0 = n_crc + n_to + n_ovr;
        f0 = n_fv;
        send_frame('0, 16'h0, 9);
        tick(4);
        chki("t1_latency", fv_rise, last + 1);
        chki("t1_fv_cycles", n_fv - f0, 1);
        expect_frame("t1_data", '0);
        chki("t1_pulses", n_crc + n_to + n_ovr - e0, 0);

        p = 112'h000102030405060708090A0B0C0D;
        send_frame(p, crc16(p), $urandom_range(0, 3));
        tick(4);
        expect_frame("t2_data", p);
        b = n_crc;
        send_frame(p, crc16(p) ^ (16'h1 << $urandom_range(0, 15)), 1);
        tick(4);
        chki("t2_crc_err", n_crc - b, 1);
        chki("t2_no_frame", got.size(), rd);
        chk("t2_busy", busy, 0);

        bus.frame_ready = 1'b0;
        p = rnd();
        u0 = n_unst;
        send_frame(p, crc16(p), 2);
        wait_fv(5);
        tick(50);
        chk("t3_fv_held", bus.frame_valid, 1);
        chk("t3_fd_held", bus.frame_data, p);
        chki("t3_unstable", n_unst - u0, 0);
        b = n_ovr;
        send(8'hA5);
        tick(2);
        chki("t3_overrun", n_ovr - b, 1);
        chk("t3_fv_after_ovr", bus.frame_valid, 1);
        bus.frame_ready = 1'b1;
        tick(3);
        expect_frame("t3_data", p);
        chk("t3_fv_drop", bus.frame_valid, 0);
        chk("t3_busy", busy, 0);

        b = n_to;
        for (int k = 0; k < 5; k++) begin
            send(8'($urandom()));
            tick(1);
        end
        l5 = last;
        tick(24);
        chki("t4_timeout", n_to - b, 1);
        chki("t4_to_cycle", to_cyc, l5 + 20);
        chk("t4_busy", busy, 0);
        p = rnd();
        send_frame(p, crc16(p), 1);
        tick(4);
        expect_frame("t4_after", p);
        b = n_to;
        p = rnd();
        c = crc16(p);
        for (int k = 0; k < 16; k++) begin
            send(byte_of(p, c, k));
            if (k == 2) tick(19);
        end
        tick(4);
        chki("t4_expiry_wins", n_to - b, 0);
        expect_frame("t4_expiry_data", p);

        e0 = n_crc + n_to + n_ovr;
        p = rnd();
        c = crc16(p);
        for (int k = 0; k < 10; k++) send(byte_of(p, c, k));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_crc_data", bus.crc_data, 0);
        q = rnd();
        send_frame(q, crc16(q), 1);
        tick(4);
        expect_frame("t5_data", q);
        bus.frame_ready = 1'b0;
        send_frame(p, c, 0);
        wait_fv(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_hold_rst_fv", bus.frame_valid, 0);
        bus.frame_ready = 1'b1;
        tick(2);
        chki("t5_no_frame", got.size(), rd);
        chki("t5_pulses", n_crc + n_to + n_ovr - e0, 0);

        b = n_ovr;
        p = rnd();
        q = rnd();
        send_frame(p, crc16(p), 0);
        tick(1);
        send_frame(q, crc16(q), 0);
        tick(4);
        expect_frame("t6_first", p);
        expect_frame("t6_second", q);
        chki("t6_no_overrun", n_ovr - b, 0);
        p = rnd();
        send_frame(p, crc16(p), 0);
        send(8'h5A);
        tick(4);
        chki("t6_check_overrun", n_ovr - b, 1);
        expect_frame("t6_after_ovr", p);

        b = n_crc;
        ncor = 0;
        for (int f = 0; f < 8; f++) begin
            p = rnd();
            c = crc16(p);
            if ($urandom_range(0, 2) == 0) begin
                c = c ^ 16'($urandom_range(1, 65535));
                ncor++;
            end else begin
                exp_q.push_back(p);
            end
            send_frame(p, c, $urandom_range(0, 2));
            tick(1 + $urandom_range(0, 3));
        end
        tick(4);
        chki("rnd_crc_errs", n_crc - b, ncor);
        chki("rnd_nframes", got.size() - rd, exp_q.size());
        foreach (exp_q[i]) expect_frame("rnd_data", exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
